stopwatch_display_mux: RTL and testbench
========================================

STOPWATCH_DISPLAY_MUX -- requirements
Module: stopwatch_display_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk_i cycles per digit slot; legal range 64 and up.
REQ-002 clk_i  in  1  system clock; all state sampled on rising edge.
REQ-003 reset_ni  in  1  asynchronous, active-low reset.
REQ-004 ms_i  in  10  stopwatch milliseconds, binary.
REQ-005 sec_i  in  6  stopwatch seconds, binary.
REQ-006 min_i  in  6  stopwatch minutes, binary.
REQ-007 hour_i  in  5  stopwatch hours, binary.
REQ-008 an_o  out  8  digit anodes, active low, one-hot-low while scanning.
REQ-009 seg_o  out  7  segments {g,f,e,d,c,b,a}, active low.
REQ-010 dp_o  out  1  decimal point, active low.

Function
REQ-011 Digit map, slot 7..0: hour tens, hour ones, min tens, min ones, sec tens, sec ones, ms hundreds, ms tens; ms ones not shown.
REQ-012 Divider counts 0..REFRESH_DIV-1; scan index 0..7 advances on divider terminal count and wraps 7->0.
REQ-013 an_o bit[index] low, all others high; seg_o/dp_o registered, same cycle as an_o.
REQ-014 dp_o low on slots 6, 4, 2; high elsewhere.
REQ-015 Frame start = cycle where index wraps 7->0: snapshot all four inputs into holding registers.
REQ-016 One shared serial binary-to-BCD (shift-add-3) converter, 10-bit input, processes fields in order ms, sec, min, hour.
REQ-017 Converter FSM: IDLE -> LOAD (1 cycle) -> SHIFT (10 cycles) -> STORE (1 cycle) -> LOAD for next field, or COMMIT after hour -> IDLE.
REQ-018 COMMIT copies all eight BCD digits to display registers in one cycle; displayed value changes 48 cycles after snapshot, never partially.
REQ-019 ms_i above 999 saturates to 999 at snapshot; sec_i/min_i up to 63 and hour_i up to 31 shown as-is.
REQ-020 Frame start while FSM not IDLE is ignored (no re-snapshot); unreachable for legal REFRESH_DIV.
REQ-021 Input changes between snapshots have no effect on displayed digits.
REQ-022 seg encoding: 0-9 standard; digit codes 10-15 never generated; blanked digit = 7'h7F.

Reset
REQ-023 reset_ni low: an_o=8'hFF, seg_o=7'h7F, dp_o=1, divider=0, index=0, FSM=IDLE, holding and display registers all zero, immediately and asynchronously.
REQ-024 Reset mid-conversion abandons it; no COMMIT occurs; first snapshot taken at first frame start after release.
REQ-025 First frame after release displays 00000000 until first COMMIT.

Configuration
REQ-026 Macro STOPWATCH_LEAD_BLANK_EN defined: hour tens digit blanked (seg_o=7'h7F, anode still driven) when zero.
REQ-027 Macro undefined: hour tens digit always shown, including 0.

Structure
REQ-028 Shared package stopwatch_pkg holds seven-segment code constants, blank code, digit-slot index constants, and converter FSM state enum.
REQ-029 Converter is sub-module stopwatch_bin2bcd: 10-bit in, start/busy/done handshake, three BCD nibbles out, 12 cycles from start to done.
REQ-030 Top holds divider, scan index, snapshot, field sequencer, display registers, segment decode.

Verification
REQ-031 REFRESH_DIV=64, inputs 12h/34m/56s/789ms, run 2 frames -> slots 7..0 show 1,2,3,4,5,6,7,8; dp low on slots 6,4,2.
REQ-032 ms_i=1023 -> ms digits show 9,9; sec_i=63 -> 6,3.
REQ-033 Change inputs mid-frame -> display unchanged until 48 cycles after next frame start, then all digits update in one cycle.
REQ-034 reset_ni low 20 cycles into conversion -> outputs at reset values same cycle; after release, first frame shows zeros, second shows inputs.
REQ-035 hour_i=5 with STOPWATCH_LEAD_BLANK_EN -> slot 7 seg_o=7'h7F; without macro -> slot 7 shows 0 (7'h40).
REQ-036 Anode check over 16 slots -> exactly one an_o bit low each slot, order 0..7, each held exactly REFRESH_DIV cycles.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants, FSM state type and helpers for the stopwatch display.
// Segment codes are active low, ordered {g,f,e,d,c,b,a}.
package stopwatch_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [2:0] SLOT_MS_TENS   = 3'd0;
    localparam logic [2:0] SLOT_MS_HUND   = 3'd1;
    localparam logic [2:0] SLOT_SEC_ONES  = 3'd2;
    localparam logic [2:0] SLOT_SEC_TENS  = 3'd3;
    localparam logic [2:0] SLOT_MIN_ONES  = 3'd4;
    localparam logic [2:0] SLOT_MIN_TENS  = 3'd5;
    localparam logic [2:0] SLOT_HOUR_ONES = 3'd6;
    localparam logic [2:0] SLOT_HOUR_TENS = 3'd7;

    localparam int unsigned BIN_W  = 10;
    localparam int unsigned BCD_W  = 12;
    localparam int unsigned SR_W   = BIN_W + BCD_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_STORE
    } cnv_state_t;

    typedef enum logic [1:0] {
        FLD_MS,
        FLD_SEC,
        FLD_MIN,
        FLD_HOUR
    } field_t;

    // One shift-add-3 iteration over {bcd[11:0], bin[9:0]}.
    function automatic logic [SR_W-1:0] dabble_step(
        input logic [SR_W-1:0] sr
    );
        logic [SR_W-1:0] t;
        t = sr;
        for (int i = 0; i < 3; i++) begin
            if (t[BIN_W+4*i +: 4] >= 4'd5) begin
                t[BIN_W+4*i +: 4] = t[BIN_W+4*i +: 4] + 4'd3;
            end
        end
        return t << 1;
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/stopwatch_display_mux_if.sv
// Stopwatch time fields in, scanned seven-segment drive out.
// master drives the time fields, slave is the display mux.
interface stopwatch_display_mux_if;

    logic [9:0] ms_i;
    logic [5:0] sec_i;
    logic [5:0] min_i;
    logic [4:0] hour_i;
    logic [7:0] an_o;
    logic [6:0] seg_o;
    logic       dp_o;

    modport master (
        output ms_i,
        output sec_i,
        output min_i,
        output hour_i,
        input  an_o,
        input  seg_o,
        input  dp_o
    );

    modport slave (
        input  ms_i,
        input  sec_i,
        input  min_i,
        input  hour_i,
        output an_o,
        output seg_o,
        output dp_o
    );

endinterface

// File: rtl/stopwatch_bin2bcd.sv
// Serial shift-add-3 binary to BCD converter, 10-bit in, three nibbles out.
// done_o pulses with bcd_o valid 12 cycles after start_i is sampled.
module stopwatch_bin2bcd
    import stopwatch_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [BCD_W-1:0] bcd_o
);

    cnv_state_t      st_q;
    logic [SR_W-1:0] sr_q;
    logic [SR_W-1:0] sr_nx;
    logic [3:0]      cnt_q;

    assign sr_nx = dabble_step(sr_q);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            st_q   <= ST_IDLE;
            sr_q   <= '0;
            cnt_q  <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            bcd_o  <= '0;
        end else begin
            done_o <= 1'b0;
            unique case (st_q)
                ST_IDLE: begin
                    if (start_i) begin
                        st_q   <= ST_LOAD;
                        busy_o <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    sr_q  <= {{BCD_W{1'b0}}, bin_i};
                    cnt_q <= '0;
                    st_q  <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    sr_q  <= sr_nx;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(BIN_W - 1)) begin
                        st_q   <= ST_STORE;
                        done_o <= 1'b1;
                        bcd_o  <= sr_nx[SR_W-1:BIN_W];
                    end
                end
                ST_STORE: begin
                    // Chaining straight into LOAD keeps fields 12 cycles apart.
                    if (start_i) begin
                        st_q <= ST_LOAD;
                    end else begin
                        st_q   <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    st_q   <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/stopwatch_display_mux.sv
// Eight-digit multiplexed stopwatch display with a shared BCD converter.
// Define STOPWATCH_LEAD_BLANK_EN to blank a zero hour-tens digit.
module stopwatch_display_mux
    import stopwatch_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    stopwatch_display_mux_if.slave  disp_if
);

    localparam int unsigned DW = $clog2(REFRESH_DIV);

    logic [DW-1:0]      div_q;
    logic [2:0]         idx_q;
    logic [2:0]         idx_d;
    logic               tc;
    logic               snap;
    logic               commit;

    logic [BIN_W-1:0]   ms_sat;
    logic [BIN_W-1:0]   ms_h;
    logic [5:0]         sec_h;
    logic [5:0]         min_h;
    logic [4:0]         hour_h;

    field_t             fld_q;
    logic               seq_on_q;
    logic               cnv_start;
    logic               cnv_busy;
    logic               cnv_done;
    logic [BIN_W-1:0]   cnv_bin;
    logic [BCD_W-1:0]   cnv_bcd;

    logic [7:0]         ms_st;
    logic [7:0]         sec_st;
    logic [7:0]         min_st;
    logic [7:0][3:0]    disp_q;
    logic [7:0][3:0]    disp_d;
    logic [3:0]         cur_dig;
    logic [6:0]         cur_seg;
    logic               cur_dp_n;

    assign tc     = (div_q == DW'(REFRESH_DIV - 1));
    assign idx_d  = tc ? idx_q + 3'd1 : idx_q;
    assign snap   = tc && (idx_q == 3'd7) && !seq_on_q && !cnv_busy;
    assign commit = cnv_done && (fld_q == FLD_HOUR);
    assign ms_sat = (disp_if.ms_i > 10'd999) ? 10'd999 : disp_if.ms_i;

    assign cnv_start = snap || (cnv_done && (fld_q != FLD_HOUR));

    always_comb begin
        cnv_bin = '0;
        unique case (fld_q)
            FLD_MS:   cnv_bin = ms_h;
            FLD_SEC:  cnv_bin = {4'd0, sec_h};
            FLD_MIN:  cnv_bin = {4'd0, min_h};
            FLD_HOUR: cnv_bin = {5'd0, hour_h};
            default:  cnv_bin = '0;
        endcase
    end

    // Outputs are decoded from next-state values so segments track the anode.
    assign disp_d = commit ? {cnv_bcd[7:0], min_st, sec_st, ms_st}
                           : disp_q;

    always_comb begin
        cur_dig = disp_d[idx_d];
        cur_seg = seg_encode(cur_dig);
`ifdef STOPWATCH_LEAD_BLANK_EN
        if (idx_d == SLOT_HOUR_TENS && cur_dig == 4'd0) begin
            cur_seg = SEG_BLANK;
        end
`endif
        cur_dp_n = !((idx_d == SLOT_HOUR_ONES) ||
                     (idx_d == SLOT_MIN_ONES)  ||
                     (idx_d == SLOT_SEC_ONES));
    end

    stopwatch_bin2bcd u_bin2bcd (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .start_i  (cnv_start),
        .bin_i    (cnv_bin),
        .busy_o   (cnv_busy),
        .done_o   (cnv_done),
        .bcd_o    (cnv_bcd)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            div_q         <= '0;
            idx_q         <= '0;
            ms_h          <= '0;
            sec_h         <= '0;
            min_h         <= '0;
            hour_h        <= '0;
            fld_q         <= FLD_MS;
            seq_on_q      <= 1'b0;
            ms_st         <= '0;
            sec_st        <= '0;
            min_st        <= '0;
            disp_q        <= '0;
            disp_if.an_o  <= 8'hFF;
            disp_if.seg_o <= SEG_BLANK;
            disp_if.dp_o  <= 1'b1;
        end else begin
            div_q  <= tc ? '0 : div_q + DW'(1);
            idx_q  <= idx_d;
            disp_q <= disp_d;

            if (snap) begin
                ms_h     <= ms_sat;
                sec_h    <= disp_if.sec_i;
                min_h    <= disp_if.min_i;
                hour_h   <= disp_if.hour_i;
                fld_q    <= FLD_MS;
                seq_on_q <= 1'b1;
            end

            if (cnv_done) begin
                unique case (fld_q)
                    FLD_MS:   ms_st    <= cnv_bcd[11:4];
                    FLD_SEC:  sec_st   <= cnv_bcd[7:0];
                    FLD_MIN:  min_st   <= cnv_bcd[7:0];
                    FLD_HOUR: seq_on_q <= 1'b0;
                    default:  seq_on_q <= 1'b0;
                endcase
                fld_q <= field_t'(fld_q + 2'd1);
            end

            disp_if.an_o  <= ~(8'd1 << idx_d);
            disp_if.seg_o <= cur_seg;
            disp_if.dp_o  <= cur_dp_n;
        end
    end

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// Randomized bench for stopwatch_display_mux against a frame-level model.
// Honours STOPWATCH_LEAD_BLANK_EN when it is defined for the build.
module tb_stopwatch_display_mux;

    localparam int DIV   = 64;
    localparam int FRAME = 8 * DIV;
    localparam int LAT   = 48;
`ifdef STOPWATCH_LEAD_BLANK_EN
    localparam bit LEAD = 1'b1;
`else
    localparam bit LEAD = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] ms_v  = '0;
    logic [5:0] sec_v = '0;
    logic [5:0] min_v = '0;
    logic [4:0] hr_v  = '0;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: edges since release, pending snapshot, digits shown per slot.
    int n          = 0;
    int shown[8]   = '{default: 0};
    int pend[8]    = '{default: 0};
    int pend_at    = 0;
    bit pend_valid = 1'b0;

    stopwatch_display_mux_if sw_if ();

    assign sw_if.ms_i   = ms_v;
    assign sw_if.sec_i  = sec_v;
    assign sw_if.min_i  = min_v;
    assign sw_if.hour_i = hr_v;

    stopwatch_display_mux #(.REFRESH_DIV(DIV)) dut (
        .clk_i    (clk_i),
        .reset_ni (rst_n),
        .disp_if  (sw_if)
    );

    always #5 clk_i = ~clk_i;

    function automatic int sat_ms();
        return (int'(ms_v) > 999) ? 999 : int'(ms_v);
    endfunction

    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            n          <= 0;
            pend_valid <= 1'b0;
            for (int i = 0; i < 8; i++) shown[i] <= 0;
        end else begin
            n <= n + 1;
            if ((n + 1) % FRAME == 0 && !pend_valid) begin
                pend[0]    <= sat_ms() / 10 % 10;
                pend[1]    <= sat_ms() / 100;
                pend[2]    <= int'(sec_v) % 10;
                pend[3]    <= int'(sec_v) / 10;
                pend[4]    <= int'(min_v) % 10;
                pend[5]    <= int'(min_v) / 10;
                pend[6]    <= int'(hr_v) % 10;
                pend[7]    <= int'(hr_v) / 10;
                pend_at    <= n + 1 + LAT;
                pend_valid <= 1'b1;
            end
            if (pend_valid && n + 1 == pend_at) begin
                for (int i = 0; i < 8; i++) shown[i] <= pend[i];
                pend_valid <= 1'b0;
            end
        end
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int slot_now();
        return (n / DIV) % 8;
    endfunction

    function automatic logic [15:0] exp_out();
        int s;
        int d;
        logic [6:0] sg;
        logic [7:0] an;
        logic dp;
        if (n == 0 || !rst_n) return {8'hFF, 7'h7F, 1'b1};
        s  = slot_now();
        d  = shown[s];
        sg = seg_of(d);
        if (LEAD && s == 7 && d == 0) sg = 7'h7F;
        an = ~(8'd1 << s);
        dp = !(s == 6 || s == 4 || s == 2);
        return {an, sg, dp};
    endfunction

    function automatic logic [15:0] obs();
        return {sw_if.an_o, sw_if.seg_o, sw_if.dp_o};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        ms_v  = 10'd321;
        sec_v = 6'd45;
        min_v = 6'd17;
        hr_v  = 5'd9;
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if (obs() !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL reset_hold got %h want ffff", obs());
        end
        rst_n = 1'b1;
        for (int c = 0; c < FRAME + 80; c++) begin
            @(negedge clk_i);
            n_cmp++;
            if (obs() !== exp_out()) begin
                n_bad++;
                $display("FAIL reset_frame n=%0d got %h want %h",
                         n, obs(), exp_out());
            end
        end
    endtask

    task automatic test_known_value();
        int guard;
        ms_v  = 10'd789;
        sec_v = 6'd56;
        min_v = 6'd34;
        hr_v  = 5'd12;
        for (int c = 0; c < 2 * FRAME + 64; c++) begin
            @(negedge clk_i);
            n_cmp++;
            if (obs() !== exp_out()) begin
                n_bad++;
                $display("FAIL known_cycle n=%0d got %h want %h",
                         n, obs(), exp_out());
            end
        end
        for (int s = 0; s < 8; s++) begin
            guard = 0;
            while (slot_now() != s && guard < 600) begin
                @(negedge clk_i);
                guard++;
            end
            n_cmp++;
            if (sw_if.seg_o !== seg_of(8 - s)) begin
                n_bad++;
                $display("FAIL known_digit slot=%0d got %h want %h",
                         s, sw_if.seg_o, seg_of(8 - s));
            end
            n_cmp++;
            if (sw_if.dp_o !== !(s == 6 || s == 4 || s == 2)) begin
                n_bad++;
                $display("FAIL known_dp slot=%0d got %b", s, sw_if.dp_o);
            end
        end
    endtask

    task automatic test_saturate();
        int guard;
        int want[4];
        want = '{9, 9, 3, 6};
        ms_v  = 10'd1023;
        sec_v = 6'd63;
        min_v = 6'($urandom_range(63));
        hr_v  = 5'($urandom_range(31));
        for (int c = 0; c < 2 * FRAME + 64; c++) begin
            @(negedge clk_i);
            n_cmp++;
            if (obs() !== exp_out()) begin
                n_bad++;
                $display("FAIL sat_cycle n=%0d got %h want %h",
                         n, obs(), exp_out());
            end
        end
        for (int s = 0; s < 4; s++) begin
            guard = 0;
            while (slot_now() != s && guard < 600) begin
                @(negedge clk_i);
                guard++;
            end
            n_cmp++;
            if (sw_if.seg_o !== seg_of(want[s])) begin
                n_bad++;
                $display("FAIL sat_digit slot=%0d got %h want %h",
                         s, sw_if.seg_o, seg_of(want[s]));
            end
        end
    endtask

    task automatic test_midframe_change();
        int r;
        for (int f = 0; f < 6; f++) begin
            r = $urandom_range(FRAME - 1);
            for (int c = 0; c < FRAME; c++) begin
                if (c == r) begin
                    ms_v  = 10'($urandom_range(1023));
                    sec_v = 6'($urandom_range(63));
                    min_v = 6'($urandom_range(63));
                    hr_v  = 5'($urandom_range(31));
                end
                @(negedge clk_i);
                n_cmp++;
                if (obs() !== exp_out()) begin
                    n_bad++;
                    $display("FAIL midframe n=%0d got %h want %h",
                             n, obs(), exp_out());
                end
            end
        end
    endtask

    task automatic test_reset_mid_conv();
        int guard;
        ms_v  = 10'd345;
        sec_v = 6'($urandom_range(63));
        min_v = 6'($urandom_range(63));
        hr_v  = 5'($urandom_range(31));
        guard = 0;
        while (!(n >= FRAME && n % FRAME == 20) && guard < 2 * FRAME) begin
            @(negedge clk_i);
            guard++;
        end
        n_cmp++;
        if (guard >= 2 * FRAME) begin
            n_bad++;
            $display("FAIL midconv_wait n=%0d", n);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL midconv_async got %h want ffff", obs());
        end
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
        for (int c = 0; c < 2 * FRAME + 64; c++) begin
            @(negedge clk_i);
            n_cmp++;
            if (obs() !== exp_out()) begin
                n_bad++;
                $display("FAIL midconv_cycle n=%0d got %h want %h",
                         n, obs(), exp_out());
            end
            if (n == FRAME + LAT - 1) begin
                n_cmp++;
                if (sw_if.seg_o !== 7'h40) begin
                    n_bad++;
                    $display("FAIL midconv_zero got %h want 40",
                             sw_if.seg_o);
                end
            end
            if (n == FRAME + LAT) begin
                n_cmp++;
                if (sw_if.seg_o !== 7'h19) begin
                    n_bad++;
                    $display("FAIL midconv_first got %h want 19",
                             sw_if.seg_o);
                end
            end
        end
    endtask

    task automatic test_lead_blank();
        int guard;
        logic [6:0] want;
        hr_v  = 5'd5;
        ms_v  = 10'($urandom_range(999));
        sec_v = 6'($urandom_range(59));
        min_v = 6'($urandom_range(59));
        want  = LEAD ? 7'h7F : 7'h40;
        for (int c = 0; c < FRAME + 2 * LAT; c++) begin
            @(negedge clk_i);
            n_cmp++;
            if (obs() !== exp_out()) begin
                n_bad++;
                $display("FAIL lead_cycle n=%0d got %h want %h",
                         n, obs(), exp_out());
            end
        end
        guard = 0;
        while (slot_now() != 7 && guard < 600) begin
            @(negedge clk_i);
            guard++;
        end
        n_cmp++;
        if (sw_if.seg_o !== want || sw_if.an_o !== 8'h7F) begin
            n_bad++;
            $display("FAIL lead_slot7 seg=%h an=%h want seg=%h an=7f",
                     sw_if.seg_o, sw_if.an_o, want);
        end
    endtask

    task automatic test_anode();
        int guard;
        int s0;
        logic [7:0] want;
        guard = 0;
        while (n % DIV != 0 && guard < 2 * DIV) begin
            @(negedge clk_i);
            guard++;
        end
        s0 = slot_now();
        for (int i = 0; i < 16; i++) begin
            want = ~(8'd1 << ((s0 + i) % 8));
            for (int j = 0; j < DIV; j++) begin
                n_cmp++;
                if (sw_if.an_o !== want || $countones(~sw_if.an_o) != 1) begin
                    n_bad++;
                    $display("FAIL anode slot=%0d cyc=%0d got %h want %h",
                             i, j, sw_if.an_o, want);
                end
                @(negedge clk_i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_value();
        test_saturate();
        test_midframe_change();
        test_reset_mid_conv();
        test_lead_blank();
        test_anode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
